load_store_unit: RTL and testbench

- Execute/memory-stage block that consumes the ALU result as the effective address for loads and stores.
- Performs the data-memory transaction over a req/ack handshake.
- Generates byte enables and store-lane alignment.
- Sign- or zero-extends load data.
- Reports misalignment and bus timeout.
- Holds the pipeline via busy until the access completes.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 78 +++++++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and small helpers used for counter sizing and legality checking.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } lsu_state_t;

   // Width needed to hold the value 'timeout' (never narrower than 1 bit).
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

   // An access is rejected when its funct3 is not a supported width for its
   // direction, or when the address is not naturally aligned to that width.
   function automatic logic is_misaligned(input logic       st,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
      logic bad;
      bad = 1'b1;
      if (st) begin
         case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = a[0];
            F3_W:    bad = (a != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = a[0];
            F3_W:        bad = (a != 2'b00);
            default:     bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable generation and store-data replication
// for the request being launched, plus extraction and extension of load data
// for the access in flight.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   input  logic [2:0]  funct3_q_i,
   input  logic [1:0]  addr_lo_q_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] load_ext_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Byte enables follow the access width shifted into the addressed lane.
   always_comb begin
      be_o = 4'b0000;
      case (funct3_i[1:0])
         2'b00:   be_o = 4'b0001 << addr_lo_i;
         2'b01:   be_o = 4'b0011 << addr_lo_i;
         2'b10:   be_o = 4'b1111;
         default: be_o = 4'b0000;
      endcase
   end

   // Store data is replicated so the enabled lanes always see the value.
   always_comb begin
      wdata_o = 32'h0000_0000;
      if (is_store_i) begin
         case (funct3_i[1:0])
            2'b00:   wdata_o = {4{store_data_i[7:0]}};
            2'b01:   wdata_o = {2{store_data_i[15:0]}};
            2'b10:   wdata_o = store_data_i;
            default: wdata_o = 32'h0000_0000;
         endcase
      end else begin
         wdata_o = 32'h0000_0000;
      end
   end

   // Pick the addressed byte/halfword out of the returned word.
   always_comb begin
      byte_s = 8'h00;
      case (addr_lo_q_i)
         2'b00:   byte_s = rdata_i[7:0];
         2'b01:   byte_s = rdata_i[15:8];
         2'b10:   byte_s = rdata_i[23:16];
         2'b11:   byte_s = rdata_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo_q_i[1]) begin
         half_s = rdata_i[31:16];
      end else begin
         half_s = rdata_i[15:0];
      end
   end

   // Sign- or zero-extend the selected field according to the load type.
   always_comb begin
      load_ext_o = 32'h0000_0000;
      case (funct3_q_i)
         F3_B:    load_ext_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   load_ext_o = {24'h00_0000, byte_s};
         F3_H:    load_ext_o = {{16{half_s[15]}}, half_s};
         F3_HU:   load_ext_o = {16'h0000, half_s};
         F3_W:    load_ext_o = rdata_i;
         default: load_ext_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts an access in IDLE, rejects illegal or
// misaligned ones immediately, otherwise runs a req/ack transaction with a
// bounded wait and reports completion with a one-cycle done pulse.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int                CNT_W     = cnt_width(int'(MEM_TIMEOUT));
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

   lsu_state_t        state_q;
   logic              is_store_q;
   logic [2:0]        funct3_q;
   logic [1:0]        addr_lo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              busy_q;
   logic              done_q;
   logic [31:0]       load_data_q;
   logic              misaligned_q;
   logic              bus_err_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [3:0]        mem_be_q;

   logic [3:0]        be_s;
   logic [31:0]       wdata_s;
   logic [31:0]       load_ext_s;
   logic              req_bad_s;

   lsu_align u_align (
      .is_store_i   (is_store),
      .funct3_i     (funct3),
      .addr_lo_i    (addr[1:0]),
      .store_data_i (store_data),
      .be_o         (be_s),
      .wdata_o      (wdata_s),
      .funct3_q_i   (funct3_q),
      .addr_lo_q_i  (addr_lo_q),
      .rdata_i      (mem_rdata),
      .load_ext_o   (load_ext_s)
   );

   // Next wait count and legality of the incoming request.
   always_comb begin
      cnt_d     = cnt_q + CNT_W'(1);
      req_bad_s = is_misaligned(is_store, funct3, addr[1:0]);
   end

   // Access FSM with all outputs registered; transaction fields are captured
   // at launch and held stable for the whole access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'b000;
         addr_lo_q    <= 2'b00;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_data_q  <= 32'h0000_0000;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_wdata_q  <= 32'h0000_0000;
         mem_be_q     <= 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               done_q       <= 1'b0;
               misaligned_q <= 1'b0;
               bus_err_q    <= 1'b0;
               cnt_q        <= '0;
               if (req_valid) begin
                  is_store_q  <= is_store;
                  funct3_q    <= funct3;
                  addr_lo_q   <= addr[1:0];
                  mem_addr_q  <= {addr[31:2], 2'b00};
                  mem_wdata_q <= wdata_s;
                  mem_be_q    <= be_s;
                  busy_q      <= 1'b1;
                  if (req_bad_s) begin
                     state_q      <= DONE;
                     done_q       <= 1'b1;
                     misaligned_q <= 1'b1;
                     mem_req_q    <= 1'b0;
                     mem_we_q     <= 1'b0;
                  end else begin
                     state_q   <= ACCESS;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= is_store;
                  end
               end else begin
                  busy_q    <= 1'b0;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  if (!is_store_q) begin
                     load_data_q <= load_ext_s;
                  end
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end else if (cnt_d == TIMEOUT_C) begin
                  if (!is_store_q) begin
                     load_data_q <= 32'h0000_0000;
                  end
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  bus_err_q <= 1'b1;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               state_q      <= IDLE;
               done_q       <= 1'b0;
               misaligned_q <= 1'b0;
               bus_err_q    <= 1'b0;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign load_data  = load_data_q;
   assign misaligned = misaligned_q;
   assign bus_err    = bus_err_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single accesses with
// hand-computed lanes/results, followed by timeout, late-ack and mid-access
// reset sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] last_load;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [3:0]  ebe;
      logic [31:0] ewdata;
      logic [31:0] eload;
      logic        emis;
   } vec_t;

   vec_t vecs [16];

   load_store_unit #(.MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd);
      @(posedge clk); #1;
      req_valid  = 1'b1;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      @(posedge clk); #1;
      req_valid  = 1'b0;
   endtask

   task automatic apply(input int idx, input vec_t v);
      string t;
      t = $sformatf("v%0d", idx);
      issue(v.st, v.f3, v.a, v.sdata);
      if (v.emis) begin
         chk({t, ".done"},    32'(done), 32'd1);
         chk({t, ".mis"},     32'(misaligned), 32'd1);
         chk({t, ".mem_req"}, 32'(mem_req), 32'd0);
         chk({t, ".busy"},    32'(busy), 32'd1);
         @(posedge clk); #1;
         chk({t, ".done_off"}, 32'(done), 32'd0);
         chk({t, ".req_off"},  32'(mem_req), 32'd0);
         chk({t, ".idle"},     32'(busy), 32'd0);
      end else begin
         chk({t, ".mem_req"}, 32'(mem_req), 32'd1);
         chk({t, ".mem_we"},  32'(mem_we), 32'(v.st));
         chk({t, ".addr"},    mem_addr, {v.a[31:2], 2'b00});
         chk({t, ".be"},      32'(mem_be), 32'(v.ebe));
         chk({t, ".wdata"},   mem_wdata, v.ewdata);
         chk({t, ".early"},   32'(done), 32'd0);
         mem_rdata = v.rdata;
         mem_ack   = 1'b1;
         @(posedge clk); #1;
         mem_ack   = 1'b0;
         if (!v.st) begin
            last_load = v.eload;
         end else begin
            last_load = last_load;
         end
         chk({t, ".done"},    32'(done), 32'd1);
         chk({t, ".mis"},     32'(misaligned), 32'd0);
         chk({t, ".berr"},    32'(bus_err), 32'd0);
         chk({t, ".ldata"},   load_data, last_load);
         chk({t, ".req_off"}, 32'(mem_req), 32'd0);
         @(posedge clk); #1;
         chk({t, ".done_off"}, 32'(done), 32'd0);
         chk({t, ".idle"},     32'(busy), 32'd0);
      end
   endtask

   initial begin
      //          st    f3      addr          sdata         rdata         be       wdata         load          mis
      vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h1234_56A5, 32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0};
      vecs[2]  = '{1'b1, 3'b001, 32'h0000_0202, 32'hCAFE_BEEF, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 3'b000, 32'h0000_0102, 32'h0,         32'h80FF_7F01, 4'b0100, 32'h0,        32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{1'b0, 3'b100, 32'h0000_0102, 32'h0,         32'h80FF_7F01, 4'b0100, 32'h0,        32'h0000_00FF, 1'b0};
      vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h80FF_7F01, 4'b1100, 32'h0,        32'hFFFF_80FF, 1'b0};
      vecs[6]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h80FF_7F01, 4'b1100, 32'h0,        32'h0000_80FF, 1'b0};
      vecs[7]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'h80FF_7F01, 4'b1111, 32'h0,        32'h80FF_7F01, 1'b0};
      vecs[8]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h80FF_7F01, 4'b0010, 32'h0,        32'h0000_007F, 1'b0};
      vecs[9]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h80FF_7F01, 4'b0011, 32'h0,        32'h0000_7F01, 1'b0};
      vecs[10] = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_0033, 32'hFFFF_FFFF, 4'b0010, 32'h3333_3333, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[12] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[13] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[14] = '{1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[15] = '{1'b1, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1};

      rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      last_load = 32'h0;
      #1;
      chk("rst.busy",  32'(busy), 32'd0);
      chk("rst.done",  32'(done), 32'd0);
      chk("rst.req",   32'(mem_req), 32'd0);
      chk("rst.we",    32'(mem_we), 32'd0);
      chk("rst.ldata", load_data, 32'h0);
      chk("rst.addr",  mem_addr, 32'h0);
      chk("rst.be",    32'(mem_be), 32'd0);
      chk("rst.wdata", mem_wdata, 32'h0);
      chk("rst.mis",   32'(misaligned), 32'd0);
      chk("rst.berr",  32'(bus_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         apply(i, vecs[i]);
      end

      // No ack at all: four request cycles, then bus error with zeroed data.
      issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("to.req%0d", c), 32'(mem_req), 32'd1);
         chk($sformatf("to.done%0d", c), 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      chk("to.done",  32'(done), 32'd1);
      chk("to.berr",  32'(bus_err), 32'd1);
      chk("to.ldata", load_data, 32'h0);
      chk("to.req",   32'(mem_req), 32'd0);
      @(posedge clk); #1;
      chk("to.idle",  32'(busy), 32'd0);

      // Ack arriving on the last allowed cycle wins over the timeout.
      issue(1'b0, 3'b010, 32'h0000_0204, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      chk("late.req", 32'(mem_req), 32'd1);
      mem_rdata = 32'h1234_5678;
      mem_ack   = 1'b1;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      chk("late.done",  32'(done), 32'd1);
      chk("late.berr",  32'(bus_err), 32'd0);
      chk("late.ldata", load_data, 32'h1234_5678);
      @(posedge clk); #1;

      // Reset in the middle of an access drops everything without a done.
      issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
      chk("mrst.req_pre", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst.req",  32'(mem_req), 32'd0);
      chk("mrst.busy", 32'(busy), 32'd0);
      chk("mrst.done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_load = 32'h0;
      @(posedge clk); #1;
      chk("mrst.done2", 32'(done), 32'd0);
      chk("mrst.busy2", 32'(busy), 32'd0);
      apply(100, vecs[0]);
      apply(101, vecs[6]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
